mux8_30bits_rr_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer for the 8:1 30-bit coefficient mux (mux8_30bits).

---
 rtl/mux8_30bits_rr_arbiter.sv | 119 +++++++++++
 tb/tb_mux8_30bits_rr_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux8_30bits_rr_arbiter.sv
// mux8_30bits_rr_arbiter: round-robin burst arbiter that shares one registered 30-bit lane among 8 streams
module mux8_30bits #(
    parameter int DW = 30
) (
    input  logic [2:0]    sel,
    input  logic [DW-1:0] in1,
    input  logic [DW-1:0] in2,
    input  logic [DW-1:0] in3,
    input  logic [DW-1:0] in4,
    input  logic [DW-1:0] in5,
    input  logic [DW-1:0] in6,
    input  logic [DW-1:0] in7,
    input  logic [DW-1:0] in8,
    output logic [DW-1:0] out
);
    always_comb begin
        case (sel)
            3'd0:    out = in1;
            3'd1:    out = in2;
            3'd2:    out = in3;
            3'd3:    out = in4;
            3'd4:    out = in5;
            3'd5:    out = in6;
            3'd6:    out = in7;
            default: out = in8;
        endcase
    end
endmodule

module mux8_30bits_rr_arbiter #(
    parameter int DW    = 30,
    parameter int BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    in_valid,
    input  logic [7:0]    in_last,
    input  logic [8*DW-1:0] in_data,
    output logic [7:0]    in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [2:0]    out_src,
    output logic          out_last,
    input  logic          out_ready,
    output logic [2:0]    mux_sel,
    output logic          busy
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t        state, state_nx;
    logic [2:0]    rr_ptr, pick;
    logic [7:0]    beat_cnt;
    logic [DW-1:0] mux_out;
    logic          out_free, xfer, cap, done;

    mux8_30bits #(.DW(DW)) u_mux (
        .sel(mux_sel),
        .in1(in_data[0*DW +: DW]),
        .in2(in_data[1*DW +: DW]),
        .in3(in_data[2*DW +: DW]),
        .in4(in_data[3*DW +: DW]),
        .in5(in_data[4*DW +: DW]),
        .in6(in_data[5*DW +: DW]),
        .in7(in_data[6*DW +: DW]),
        .in8(in_data[7*DW +: DW]),
        .out(mux_out)
    );

    // descending scan so the closest valid index after rr_ptr wins
    always_comb begin
        pick = rr_ptr;
        for (int k = 7; k >= 0; k--)
            if (in_valid[rr_ptr + 3'(k)]) pick = rr_ptr + 3'(k);
    end

    assign busy     = state == GRANT;
    assign out_free = !out_valid || out_ready;
    assign in_ready = (busy && out_free) ? 8'd1 << mux_sel : 8'd0;
    assign xfer     = busy && out_free && in_valid[mux_sel];
    assign cap      = in_last[mux_sel] || beat_cnt == 8'(BURST - 1);
    assign done     = busy && (!in_valid[mux_sel] || (xfer && cap));

    always_comb begin
        state_nx = state;
        if (state == IDLE && |in_valid) state_nx = GRANT;
        if (done) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            mux_sel   <= '0;
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            out_last  <= 1'b0;
        end else begin
            if (!busy && |in_valid) begin
                mux_sel  <= pick;
                beat_cnt <= '0;
            end
            if (done) rr_ptr <= mux_sel + 3'd1;
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= mux_out;
                out_src   <= mux_sel;
                out_last  <= cap;
                beat_cnt  <= cap ? 8'd0 : beat_cnt + 8'd1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mux8_30bits_rr_arbiter.sv
// tb_mux8_30bits_rr_arbiter: vector table plus scoreboard check of the round-robin lane arbiter
module tb_mux8_30bits_rr_arbiter;
    localparam int DW = 30;

    typedef struct packed {
        logic [2:0]    src;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        int            src;
        logic [DW-1:0] data;
        logic          last;
        logic [7:0]    exp_ready;
        logic          exp_last;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    in_valid = '0;
    logic [7:0]    in_last = '0;
    logic [8*DW-1:0] in_data = '0;
    logic [7:0]    in_ready;
    logic          out_valid, out_last, busy;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic [2:0]    out_src, mux_sel;

    beat_t      sb[$];
    beat_t      b;
    logic [DW:0] pmem[8][32];
    int         ph[8] = '{default: 0};
    int         pt[8] = '{default: 0};
    int         stall = 0;
    int         checks = 0;
    int         fails = 0;
    logic [7:0] hs = '0;

    always #5 clk = ~clk;

    mux8_30bits_rr_arbiter #(.DW(DW), .BURST(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_last(in_last),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_src(out_src),
        .out_last(out_last),
        .out_ready(out_ready),
        .mux_sel(mux_sel),
        .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic put(input int r, input logic [DW-1:0] d, input logic l);
        pmem[r][pt[r] % 32] = {l, d};
        pt[r]++;
    endtask

    task automatic expect_out(input int r, input logic [DW-1:0] d, input logic l);
        sb.push_back(beat_t'{src: 3'(r), data: d, last: l});
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busy || out_valid) && n < 300) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("drain_timeout", 32'(n >= 300), 32'd0);
        @(posedge clk);
        #2;
    endtask

    // producers and output monitor: drive at negedge, sample handshakes 1 ns later
    always @(negedge clk) begin
        if (!rst_n) begin
            hs = '0;
            for (int i = 0; i < 8; i++) ph[i] = pt[i];
            sb.delete();
        end
        for (int i = 0; i < 8; i++) begin
            if (hs[i]) ph[i]++;
            in_valid[i] = ph[i] < pt[i];
            {in_last[i], in_data[i*DW +: DW]} = pmem[i][ph[i] % 32];
        end
        out_ready = stall == 0;
        if (stall > 0) stall--;
        #1;
        hs = in_valid & in_ready;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL out_unexpected: got src %0d data %0h, expected no word", out_src, out_data);
            end else begin
                b = sb.pop_front();
                chk("sb_out_src", 32'(out_src), 32'(b.src));
                chk("sb_out_data", 32'(out_data), 32'(b.data));
                chk("sb_out_last", 32'(out_last), 32'(b.last));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t        vt[5];
        logic [17:0] bz;
        logic [DW-1:0] held;
        vt[0] = '{3, 30'h1234567, 1'b1, 8'h08, 1'b1};
        vt[1] = '{7, 30'h3FFFFFFF, 1'b1, 8'h80, 1'b1};
        vt[2] = '{0, 30'h0000000, 1'b1, 8'h01, 1'b1};
        vt[3] = '{5, 30'h2AAAAAAA, 1'b0, 8'h20, 1'b0};
        vt[4] = '{1, 30'h15555555, 1'b1, 8'h02, 1'b1};

        repeat (2) @(posedge clk);
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_mux_sel", 32'(mux_sel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_src", 32'(out_src), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // all eight requesting, single-word packets: 0..7 then 0, one idle cycle between grants
        put(0, 30'h0000A00, 1'b1);
        put(0, 30'h0000A01, 1'b1);
        for (int i = 1; i < 8; i++) put(i, 30'(32'hA10 + i), 1'b1);
        expect_out(0, 30'h0000A00, 1'b1);
        for (int i = 1; i < 8; i++) expect_out(i, 30'(32'hA10 + i), 1'b1);
        expect_out(0, 30'h0000A01, 1'b1);
        @(negedge clk);
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            #2;
            bz[k] = busy;
        end
        chk("t3_busy_pattern", 32'(bz), 32'h15555);
        drain();

        for (int v = 0; v < 5; v++) begin
            put(vt[v].src, vt[v].data, vt[v].last);
            expect_out(vt[v].src, vt[v].data, vt[v].last);
            @(negedge clk);
            @(negedge clk);
            #2;
            chk($sformatf("vec%0d_mux_sel", v), 32'(mux_sel), 32'(vt[v].src));
            chk($sformatf("vec%0d_in_ready", v), 32'(in_ready), 32'(vt[v].exp_ready));
            @(negedge clk);
            #2;
            chk($sformatf("vec%0d_out_valid", v), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_out_data", v), 32'(out_data), 32'(vt[v].data));
            chk($sformatf("vec%0d_out_src", v), 32'(out_src), 32'(vt[v].src));
            chk($sformatf("vec%0d_out_last", v), 32'(out_last), 32'(vt[v].exp_last));
            drain();
        end

        // burst cap: 10 words from requester 5 end grants after words 4, 8 and 10
        for (int w = 1; w <= 10; w++) begin
            put(5, 30'(32'h500 + w), w == 10);
            expect_out(5, 30'(32'h500 + w), w % 4 == 0 || w == 10);
        end
        drain();

        // backpressure mid-burst
        for (int w = 1; w <= 6; w++) begin
            put(4, 30'(32'h4000 + w), w == 6);
            expect_out(4, 30'(32'h4000 + w), w == 4 || w == 6);
        end
        repeat (3) @(posedge clk);
        #2;
        stall = 3;
        @(negedge clk);
        #2;
        held = out_data;
        chk("t5_out_valid_stall", 32'(out_valid), 32'd1);
        chk("t5_in_ready_stall0", 32'(in_ready), 32'd0);
        for (int k = 1; k < 3; k++) begin
            @(negedge clk);
            #2;
            chk($sformatf("t5_in_ready_stall%0d", k), 32'(in_ready), 32'd0);
            chk($sformatf("t5_out_data_held%0d", k), 32'(out_data), 32'(held));
        end
        drain();

        // granted requester drops after one word; pointer moves past it
        put(2, 30'h2222222, 1'b0);
        expect_out(2, 30'h2222222, 1'b0);
        @(posedge clk);
        #2;
        put(1, 30'h1111111, 1'b1);
        put(6, 30'h6666666, 1'b1);
        expect_out(6, 30'h6666666, 1'b1);
        expect_out(1, 30'h1111111, 1'b1);
        @(negedge clk);
        #2;
        chk("t6_sel_first", 32'(mux_sel), 32'd2);
        @(negedge clk);
        #2;
        chk("t6_busy_xfer", 32'(busy), 32'd1);
        @(negedge clk);
        #2;
        chk("t6_idle_after_drop", 32'(busy), 32'd0);
        @(negedge clk);
        #2;
        chk("t6_busy_regrant", 32'(busy), 32'd1);
        chk("t6_sel_next", 32'(mux_sel), 32'd6);
        drain();

        // asynchronous reset in the middle of a burst
        for (int w = 1; w <= 8; w++) begin
            put(3, 30'(32'h3000 + w), 1'b0);
            expect_out(3, 30'(32'h3000 + w), w == 4 || w == 8);
        end
        repeat (3) @(posedge clk);
        #3;
        chk("t1_pre_out_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t1_out_valid", 32'(out_valid), 32'd0);
        chk("t1_in_ready", 32'(in_ready), 32'd0);
        chk("t1_mux_sel", 32'(mux_sel), 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        put(5, 30'h0505050, 1'b1);
        put(2, 30'h0202020, 1'b1);
        expect_out(2, 30'h0202020, 1'b1);
        expect_out(5, 30'h0505050, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #2;
        chk("t1_first_grant", 32'(mux_sel), 32'd2);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
